nas_msg_loader: RTL and testbench

Upstream stage of the LTE intrusion-detection datapath. Accepts one NAS message at a time as a byte stream. Packs the bytes little-endian into 32-bit words, writes them and a length header into the shared message SRAM, then runs the valid/ready start handshake with the IDS detector core (`MyDesign`). It accepts no new message until the detector reports completion.

---
 rtl/nas_msg_loader.sv | 160 ++++++++++++++++
 tb/tb_nas_msg_loader.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nas_msg_loader.sv
// NAS message loader: packs a byte stream little-endian into 32-bit SRAM words,
// writes a byte-count header at word 0, then runs the start handshake with the detector.
module nas_msg_loader #(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned MAX_BYTES  = 1024
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [7:0]            in_data,
   input  logic                  in_last,
   output logic                  sram_write_enable,
   output logic [ADDR_WIDTH-1:0] sram_write_address,
   output logic [31:0]           sram_write_data,
   output logic                  dut_valid,
   input  logic                  dut_ready,
   output logic                  busy,
   output logic                  overflow,
   output logic [15:0]           msg_count
);

   localparam int unsigned   CW      = $clog2(MAX_BYTES) + 1;
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BYTES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_COLLECT,
      S_FLUSH,
      S_HEADER,
      S_START,
      S_WAIT_DONE
   } state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [31:0]           pack_q, pack_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic                  dv_q, dv_d;
   logic                  ovf_q, ovf_d;
   logic [15:0]           mcnt_q, mcnt_d;

   logic                  accept;
   logic [CW-1:0]         last_idx;
   logic [ADDR_WIDTH-1:0] cur_word;
   logic [ADDR_WIDTH-1:0] last_word;

   assign in_ready = reset_n && ((state_q == S_IDLE) || (state_q == S_COLLECT));
   assign accept   = in_valid && in_ready;
   assign busy     = (state_q != S_IDLE);

   assign cur_word  = ADDR_WIDTH'(cnt_q >> 2) + ADDR_WIDTH'(1);
   assign last_idx  = cnt_q - CW'(1);
   assign last_word = ADDR_WIDTH'(last_idx >> 2) + ADDR_WIDTH'(1);

   assign sram_write_enable  = we_q;
   assign sram_write_address = addr_q;
   assign sram_write_data    = wdata_q;
   assign dut_valid          = dv_q;
   assign overflow           = ovf_q;
   assign msg_count          = mcnt_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pack_d  = pack_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      ovf_d   = ovf_q;
      mcnt_d  = mcnt_q;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               cnt_d   = CW'(1);
               pack_d  = {24'h0, in_data};
               ovf_d   = 1'b0;
               state_d = in_last ? S_FLUSH : S_COLLECT;
            end
         end

         S_COLLECT: begin
            if (accept) begin
               if (cnt_q == MAX_CNT) begin
                  ovf_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CW'(1);
                  // Lane 0 restarts the word, so the last full word survives for the flush rewrite
                  if (cnt_q[1:0] == 2'd0) pack_d = {24'h0, in_data};
                  else                    pack_d[{cnt_q[1:0], 3'b000} +: 8] = in_data;
                  if ((cnt_q[1:0] == 2'd3) && !in_last) begin
                     we_d    = 1'b1;
                     addr_d  = cur_word;
                     wdata_d = pack_d;
                  end
               end
               if (in_last) state_d = S_FLUSH;
            end
         end

         S_FLUSH: begin
            we_d    = 1'b1;
            addr_d  = last_word;
            wdata_d = pack_q;
            state_d = S_HEADER;
         end

         S_HEADER: begin
            we_d    = 1'b1;
            addr_d  = '0;
            wdata_d = 32'(cnt_q);
            state_d = S_START;
         end

         S_START: begin
            if (!dut_ready) state_d = S_WAIT_DONE;
         end

         S_WAIT_DONE: begin
            if (dut_ready) begin
               mcnt_d  = mcnt_q + 16'd1;
               state_d = S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase

      // Registered request: raised one cycle into START, dropped on the edge that sees ready low
      dv_d = (state_q == S_START) && dut_ready;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         pack_q  <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         dv_q    <= 1'b0;
         ovf_q   <= 1'b0;
         mcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pack_q  <= pack_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         dv_q    <= dv_d;
         ovf_q   <= ovf_d;
         mcnt_q  <= mcnt_d;
      end
   end

endmodule

// File: tb/tb_nas_msg_loader.sv
// Bench for nas_msg_loader: directed and random messages checked against an
// SRAM write-sequence model derived from byte counts and word layout.
module tb_nas_msg_loader;

   localparam int unsigned AW   = 16;
   localparam int unsigned MAXB = 8;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          in_valid;
   logic          in_ready;
   logic [7:0]    in_data;
   logic          in_last;
   logic          sram_write_enable;
   logic [AW-1:0] sram_write_address;
   logic [31:0]   sram_write_data;
   logic          dut_valid;
   logic          dut_ready;
   logic          busy;
   logic          overflow;
   logic [15:0]   msg_count;

   nas_msg_loader #(.ADDR_WIDTH(AW), .MAX_BYTES(MAXB)) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .in_valid          (in_valid),
      .in_ready          (in_ready),
      .in_data           (in_data),
      .in_last           (in_last),
      .sram_write_enable (sram_write_enable),
      .sram_write_address(sram_write_address),
      .sram_write_data   (sram_write_data),
      .dut_valid         (dut_valid),
      .dut_ready         (dut_ready),
      .busy              (busy),
      .overflow          (overflow),
      .msg_count         (msg_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned addr;
      logic [31:0] data;
      int          cyc;
   } wr_t;

   wr_t        wrs[$];
   wr_t        exp_wrs[$];
   logic [7:0] msg[$];
   int         cyc = 0;
   int         acc_cnt = 0;
   int         last_cyc = 0;
   int         dv_rise_cyc = 0;
   logic       dv_prev = 1'b0;
   int         checks = 0;
   int         errors = 0;
   int         timeouts;
   logic       ovf_first;
   int         exp_mc;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (in_valid && in_ready) begin
         acc_cnt++;
         if (in_last) last_cyc = cyc + 1;
      end
      if (sram_write_enable)
         wrs.push_back('{addr: int'(sram_write_address), data: sram_write_data, cyc: cyc});
      if (dut_valid && !dv_prev) dv_rise_cyc = cyc;
      dv_prev = dut_valid;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached (checks=%0d)", checks);
      $fatal(1, "time limit");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] word_of(input int unsigned w, input int unsigned s);
      logic [31:0] r = '0;
      for (int unsigned b = 0; b < 4; b++)
         if (4 * w + b < s) r[8 * b +: 8] = msg[4 * w + b];
      return r;
   endfunction

   // Expected writes: every full word whose 4th byte is not the message's last byte,
   // then the word holding the last stored byte, then the saturated byte count.
   task automatic build_expected();
      int unsigned n = msg.size();
      int unsigned s = (n < MAXB) ? n : MAXB;
      exp_wrs.delete();
      for (int unsigned k = 0; k < s; k++)
         if ((k % 4 == 3) && (k != n - 1))
            exp_wrs.push_back('{addr: 1 + k / 4, data: word_of(k / 4, s), cyc: 0});
      exp_wrs.push_back('{addr: 1 + (s - 1) / 4, data: word_of((s - 1) / 4, s), cyc: 0});
      exp_wrs.push_back('{addr: 0, data: s, cyc: 0});
   endtask

   task automatic send_msg(input int unsigned gap_pct, input bit hold, input bit mark_last);
      int unsigned n;
      bit ok;
      @(posedge clk); #1;
      n = msg.size();
      acc_cnt  = 0;
      timeouts = 0;
      wrs.delete();
      for (int unsigned i = 0; i < n; i++) begin
         while ($urandom_range(99) < gap_pct) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
         end
         in_valid = 1'b1;
         in_data  = msg[i];
         in_last  = mark_last && (i == n - 1);
         ok = 1'b0;
         for (int unsigned t = 0; t < 40 && !ok; t++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
         end
         if (!ok) timeouts++;
         if (i == 0) ovf_first = overflow;
      end
      in_last = 1'b0;
      if (hold) in_data = 8'hEE;
      else      in_valid = 1'b0;
   endtask

   task automatic handshake(input int unsigned drop_delay, input int unsigned low_len);
      int unsigned n = 0;
      bit bad = 1'b0;
      do begin
         @(negedge clk);
         n++;
      end while (!dut_valid && n < 20);
      chk1("dut_valid_rise", dut_valid, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int unsigned d = 0; d < drop_delay; d++) begin
         @(negedge clk);
         if (!dut_valid || !busy) bad = 1'b1;
         @(posedge clk); #1;
      end
      dut_ready = 1'b0;
      @(negedge clk);
      if (!dut_valid) bad = 1'b1;
      chk1("dut_valid_held", bad, 1'b0);
      @(negedge clk);
      chk1("dut_valid_fall", dut_valid, 1'b0);
      bad = 1'b0;
      for (int unsigned d = 0; d < low_len; d++) begin
         @(negedge clk);
         if (dut_valid || !busy || in_ready) bad = 1'b1;
      end
      chk1("wait_done_stable", bad, 1'b0);
      @(posedge clk); #1;
      dut_ready = 1'b1;
      @(negedge clk);
      chk1("no_early_accept", in_ready, 1'b0);
      @(negedge clk);
      exp_mc++;
      chk("msg_count", 32'(msg_count), 32'(exp_mc));
      chk1("in_ready_after_done", in_ready, 1'b1);
      chk1("busy_after_done", busy, 1'b0);
   endtask

   task automatic verify(input string name);
      int unsigned nw;
      build_expected();
      chk({name, ".send_timeouts"}, timeouts, 0);
      chk({name, ".accepted_bytes"}, acc_cnt, msg.size());
      chk({name, ".write_count"}, wrs.size(), exp_wrs.size());
      nw = (wrs.size() < exp_wrs.size()) ? wrs.size() : exp_wrs.size();
      for (int unsigned i = 0; i < nw; i++) begin
         chk({name, ".wr_addr"}, wrs[i].addr, exp_wrs[i].addr);
         chk({name, ".wr_data"}, wrs[i].data, exp_wrs[i].data);
      end
      if (wrs.size() >= 2) begin
         chk({name, ".flush_latency"}, wrs[wrs.size() - 2].cyc - last_cyc, 1);
         chk({name, ".header_latency"}, wrs[wrs.size() - 1].cyc - last_cyc, 2);
      end
      chk({name, ".dut_valid_latency"}, dv_rise_cyc - last_cyc, 3);
      chk1({name, ".overflow"}, overflow, msg.size() > MAXB);
      chk1({name, ".overflow_clear_first"}, ovf_first, 1'b0);
   endtask

   task automatic run_msg(input string name, input int unsigned gap_pct, input bit hold,
                          input int unsigned drop_delay, input int unsigned low_len);
      send_msg(gap_pct, hold, 1'b1);
      handshake(drop_delay, low_len);
      verify(name);
   endtask

   task automatic check_reset_outputs(input string name);
      chk1({name, ".we"}, sram_write_enable, 1'b0);
      chk({name, ".addr"}, 32'(sram_write_address), 0);
      chk({name, ".data"}, sram_write_data, 0);
      chk1({name, ".dut_valid"}, dut_valid, 1'b0);
      chk1({name, ".busy"}, busy, 1'b0);
      chk1({name, ".overflow"}, overflow, 1'b0);
      chk({name, ".msg_count"}, 32'(msg_count), 0);
   endtask

   initial begin
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      in_last   = 1'b0;
      dut_ready = 1'b1;
      exp_mc    = 0;
      ovf_first = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      chk1("reset.in_ready_low", in_ready, 1'b0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(negedge clk);
      chk1("reset.in_ready_high", in_ready, 1'b1);

      msg = '{8'h07, 8'h44, 8'h0D, 8'h00, 8'h01, 8'h02};
      run_msg("six", 0, 1'b0, 2, 50);

      msg = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      run_msg("four", 0, 1'b0, 1, 3);

      msg.delete();
      for (int unsigned i = 0; i < 10; i++) msg.push_back(8'(i));
      run_msg("ovf", 0, 1'b0, 0, 2);

      msg = '{8'h07, 8'h44, 8'h0D, 8'h00, 8'h01, 8'h02};
      run_msg("six_backpressure", 60, 1'b1, 1, 4);

      // Abandon a message after 5 bytes with a one-cycle reset
      msg = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
      send_msg(0, 1'b0, 1'b0);
      reset_n = 1'b0;
      @(negedge clk);
      chk1("midreset.in_ready_low", in_ready, 1'b0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      wrs.delete();
      exp_mc = 0;
      @(negedge clk);
      check_reset_outputs("midreset");
      chk1("midreset.in_ready", in_ready, 1'b1);
      repeat (5) @(negedge clk);
      chk("midreset.no_writes", wrs.size(), 0);

      msg = '{8'h5A, 8'hC3};
      run_msg("two_after_reset", 0, 1'b0, 1, 2);

      for (int unsigned m = 0; m < 10; m++) begin
         int unsigned len = $urandom_range(12, 1);
         msg.delete();
         for (int unsigned i = 0; i < len; i++) msg.push_back(8'($urandom));
         run_msg($sformatf("rand%0d", m), $urandom_range(70), 1'($urandom_range(1)),
                 $urandom_range(3), $urandom_range(20, 1));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
